// File: rtl/risk_pkg.sv
// Shared constants and encodings for the risk tile command sequencer.
package risk_pkg;

  localparam int ADDR_W        = 15;
  localparam int STRIDE_W      = 14;
  localparam int TILE_EDGE     = 4;
  localparam int DEF_LOAD_LAT  = 4;
  localparam int DEF_STORE_LAT = 2;
  localparam int DEF_NREGS     = 3;

  typedef enum logic [2:0] {
    FUNC_LOAD  = 3'b000,
    FUNC_STORE = 3'b001,
    FUNC_ZERO  = 3'b010,
    FUNC_NOP   = 3'b111
  } risk_func_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_ZERO  = 2'd2,
    OP_RSVD  = 2'd3
  } risk_op_e;

endpackage

// File: rtl/risk_addr_walk.sv
// Tile origin walker: row/col address accumulators plus tile x/y counters.
module risk_addr_walk
  import risk_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] step_x,
  input  logic [ADDR_W-1:0] step_y,
  input  logic [3:0]        tiles_x,
  input  logic [3:0]        tiles_y,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  logic [ADDR_W-1:0] row;
  logic [3:0]        tx;
  logic [3:0]        ty;
  logic              x_more;

  always_comb begin
    x_more = ({1'b0, tx} + 5'd1) < {1'b0, tiles_x};
    last   = !x_more && (({1'b0, ty} + 5'd1) >= {1'b0, tiles_y});
  end

  // Address sums wrap silently modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      tx  <= '0;
      ty  <= '0;
    end else if (restart) begin
      row <= base;
      col <= base;
      tx  <= '0;
      ty  <= '0;
    end else if (step) begin
      if (x_more) begin
        col <= col + step_x;
        tx  <= tx + 4'd1;
      end else begin
        row <= row + step_y;
        col <= row + step_y;
        tx  <= '0;
        ty  <= ty + 4'd1;
      end
    end
  end

endmodule

// File: rtl/risk_tile_seq.sv
// Walks a 2D block descriptor tile by tile and issues risk unit commands.
// Optional RISK_SEQ_ABORT_EN adds an abort input that cuts the walk short.
module risk_tile_seq
  import risk_pkg::*;
#(
  parameter int LOAD_LAT  = DEF_LOAD_LAT,
  parameter int STORE_LAT = DEF_STORE_LAT,
  parameter int NREGS     = DEF_NREGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [STRIDE_W-1:0] stride_x,
  input  logic [STRIDE_W-1:0] stride_y,
  input  logic [3:0]          tiles_x,
  input  logic [3:0]          tiles_y,
  input  logic [4:0]          reg_base,
  output logic [2:0]          risk_func,
  output logic [4:0]          risk_reg,
  output logic [ADDR_W-1:0]   risk_addr,
  output logic [STRIDE_W-1:0] risk_stride_x,
  output logic [STRIDE_W-1:0] risk_stride_y,
  output logic                busy,
  output logic                done
`ifdef RISK_SEQ_ABORT_EN
  ,
  input  logic                abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ADDR, S_FIRE, S_NEXT, S_DONE
  } state_e;

  state_e              state, next_state;
  risk_op_e            op_q;
  logic [ADDR_W-1:0]   base_q;
  logic [STRIDE_W-1:0] sx_q, sy_q;
  logic [3:0]          tiles_x_q, tiles_y_q;
  logic [4:0]          rb_q, reg_idx, reg_mod;
  logic [7:0]          hold_cnt, hold_len;
  logic [2:0]          fire_func;
  logic                walk_restart, walk_step, walk_last, abort_w;
  logic [ADDR_W-1:0]   walk_col;

`ifdef RISK_SEQ_ABORT_EN
  always_comb abort_w = abort;
`else
  always_comb abort_w = 1'b0;
`endif

  always_comb begin
    reg_mod = 5'(int'(rb_q) % NREGS);
    case (op_q)
      OP_LOAD:  begin hold_len = 8'(LOAD_LAT - 1);  fire_func = FUNC_LOAD;  end
      OP_STORE: begin hold_len = 8'(STORE_LAT - 1); fire_func = FUNC_STORE; end
      default:  begin hold_len = '0;                fire_func = FUNC_ZERO;  end
    endcase
  end

  always_comb begin
    next_state   = state;
    risk_func    = FUNC_NOP;
    busy         = 1'b0;
    done         = 1'b0;
    walk_restart = 1'b0;
    walk_step    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (tiles_x == '0 || tiles_y == '0 || op == OP_RSVD) next_state = S_DONE;
          else                                                 next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        busy         = 1'b1;
        walk_restart = 1'b1;
        next_state   = (hold_len == '0) ? S_FIRE : S_ADDR;
      end
      S_ADDR: begin
        busy = 1'b1;
        if (abort_w)                         next_state = S_DONE;
        else if (hold_cnt + 8'd1 == hold_len) next_state = S_FIRE;
      end
      S_FIRE: begin
        busy       = 1'b1;
        risk_func  = fire_func;
        next_state = abort_w ? S_DONE : S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        walk_step = 1'b1;
        if (abort_w || walk_last) next_state = S_DONE;
        else                      next_state = (hold_len == '0) ? S_FIRE : S_ADDR;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      reg_idx       <= '0;
      hold_cnt      <= '0;
      risk_stride_x <= '0;
      risk_stride_y <= '0;
    end else begin
      state    <= next_state;
      hold_cnt <= (state == S_ADDR) ? hold_cnt + 8'd1 : '0;
      if (state == S_SETUP) begin
        reg_idx       <= reg_mod;
        risk_stride_x <= sx_q;
        risk_stride_y <= sy_q;
      end else if (state == S_NEXT) begin
        reg_idx <= (int'(reg_idx) + 1 >= NREGS) ? '0 : reg_idx + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && start) begin
      op_q      <= risk_op_e'(op);
      base_q    <= base_addr;
      sx_q      <= stride_x;
      sy_q      <= stride_y;
      tiles_x_q <= tiles_x;
      tiles_y_q <= tiles_y;
      rb_q      <= reg_base;
    end
  end

  risk_addr_walk u_walk (
    .clk     (clk),
    .reset   (reset),
    .restart (walk_restart),
    .step    (walk_step),
    .base    (base_q),
    .step_x  (ADDR_W'({sx_q, 2'b00})),
    .step_y  (ADDR_W'({sy_q, 2'b00})),
    .tiles_x (tiles_x_q),
    .tiles_y (tiles_y_q),
    .col     (walk_col),
    .last    (walk_last)
  );

  always_comb begin
    risk_addr = walk_col;
    risk_reg  = reg_idx;
  end

endmodule

// File: tb/tb_risk_tile_seq.sv
// Scoreboard bench for risk_tile_seq: expected commands/done are queued per descriptor.
module tb_risk_tile_seq;
  import risk_pkg::*;

  localparam int LOAD_LAT  = 4;
  localparam int STORE_LAT = 2;
  localparam int NREGS     = 3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [14:0] base_addr;
  logic [13:0] stride_x, stride_y;
  logic [3:0]  tiles_x, tiles_y;
  logic [4:0]  reg_base;
  logic [2:0]  risk_func;
  logic [4:0]  risk_reg;
  logic [14:0] risk_addr;
  logic [13:0] risk_stride_x, risk_stride_y;
  logic        busy, done;
`ifdef RISK_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  risk_tile_seq #(.LOAD_LAT(LOAD_LAT), .STORE_LAT(STORE_LAT), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
    .stride_x(stride_x), .stride_y(stride_y), .tiles_x(tiles_x), .tiles_y(tiles_y),
    .reg_base(reg_base), .risk_func(risk_func), .risk_reg(risk_reg),
    .risk_addr(risk_addr), .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y),
    .busy(busy), .done(done)
`ifdef RISK_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [2:0]  func;
    logic [14:0] addr;
    logic [4:0]  rg;
    int          at;
    logic [13:0] sx, sy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (risk_func !== FUNC_NOP || done !== 1'b0)) begin
      if (sbq.size() == 0) begin
        check("spurious_func", 32'(risk_func), 32'(FUNC_NOP));
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.is_done) begin
          check("done_pulse", 32'(done), 32'd1);
          check("done_func", 32'(risk_func), 32'(FUNC_NOP));
          check("done_cycle", 32'(cyc), 32'(e.at));
          check("done_busy", 32'(busy), 32'd0);
        end else begin
          check("fire_func", 32'(risk_func), 32'(e.func));
          check("fire_addr", 32'(risk_addr), 32'(e.addr));
          check("fire_reg", 32'(risk_reg), 32'(e.rg));
          check("fire_cycle", 32'(cyc), 32'(e.at));
          check("fire_stride_x", 32'(risk_stride_x), 32'(e.sx));
          check("fire_stride_y", 32'(risk_stride_y), 32'(e.sy));
          check("fire_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  // Reference: tile k (row-major) sits at base + 4*(x*sx + y*sy), fires after
  // SETUP plus k whole tiles of (hold + FIRE + NEXT) and its own hold cycles.
  task automatic issue(input logic [1:0] o, input logic [14:0] b, input logic [13:0] sxi,
                       input logic [13:0] syi, input logic [3:0] nx, input logic [3:0] ny,
                       input logic [4:0] rb, input bit extra, output int s);
    exp_t e;
    int   hold, n, r0;
    @(posedge clk); #1;
    s = cyc;
    op = o; base_addr = b; stride_x = sxi; stride_y = syi;
    tiles_x = nx; tiles_y = ny; reg_base = rb; start = 1'b1;
    hold = (o == 2'd0) ? LOAD_LAT - 1 : (o == 2'd1) ? STORE_LAT - 1 : 0;
    n  = (o == 2'd3) ? 0 : int'(nx) * int'(ny);
    r0 = int'(rb) % NREGS;
    for (int k = 0; k < n; k++) begin
      int x, y;
      x = k % int'(nx);
      y = k / int'(nx);
      e.is_done = 1'b0;
      e.func = 3'(o);
      e.addr = 15'(int'(b) + 4 * x * int'(sxi) + 4 * y * int'(syi));
      e.rg   = 5'((r0 + k) % NREGS);
      e.at   = s + 2 + k * (hold + 2) + hold;
      e.sx   = sxi;
      e.sy   = syi;
      sbq.push_back(e);
    end
    e = '{is_done: 1'b1, func: FUNC_NOP, addr: '0, rg: '0, at: 0, sx: '0, sy: '0};
    e.at = (n == 0) ? s + 1 : s + 2 + n * (hold + 2);
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    if (extra && n > 0) begin
      repeat (3) @(posedge clk);
      #1;
      op = 2'd0; base_addr = ~b; stride_x = 14'd3; stride_y = 14'd5;
      tiles_x = 4'd2; tiles_y = 4'd2; reg_base = 5'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; op = '0; base_addr = '0; stride_x = '0; stride_y = '0;
    tiles_x = '0; tiles_y = '0; reg_base = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_func", 32'(risk_func), 32'(FUNC_NOP));
    check("rst_reg", 32'(risk_reg), 32'd0);
    check("rst_addr", 32'(risk_addr), 32'd0);
    check("rst_stride_x", 32'(risk_stride_x), 32'd0);
    check("rst_stride_y", 32'(risk_stride_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    mon_en = 1'b1;

    issue(2'd0, 15'd100, 14'd1, 14'd64, 4'd2, 4'd2, 5'd0, 1'b0, s); drain();
    issue(2'd1, 15'd7, 14'd9, 14'd9, 4'd1, 4'd1, 5'd2, 1'b0, s);    drain();
    issue(2'd0, 15'd50, 14'd1, 14'd1, 4'd0, 4'd3, 5'd0, 1'b0, s);   drain();
    issue(2'd2, 15'd32760, 14'd2, 14'd0, 4'd2, 4'd1, 5'd4, 1'b0, s); drain();
    issue(2'd3, 15'd10, 14'd1, 14'd1, 4'd2, 4'd2, 5'd0, 1'b0, s);   drain();
    issue(2'd0, 15'd300, 14'd2, 14'd8, 4'd3, 4'd2, 5'd5, 1'b1, s);  drain();

    // Reset lands inside the second tile's address hold of a 4-tile load.
    issue(2'd0, 15'd500, 14'd1, 14'd16, 4'd4, 4'd1, 5'd0, 1'b0, s);
    repeat (7) @(posedge clk);
    #1;
    sbq.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_func", 32'(risk_func), 32'(FUNC_NOP));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(risk_addr), 32'd0);
    issue(2'd0, 15'd1000, 14'd3, 14'd2, 4'd2, 4'd1, 5'd1, 1'b0, s); drain();

    // start coinciding with reset must be dropped.
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; op = 2'd2; tiles_x = 4'd1; tiles_y = 4'd1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_start_busy2", 32'(busy), 32'd0);

`ifdef RISK_SEQ_ABORT_EN
    begin
      exp_t e;
      @(posedge clk); #1;
      s = cyc;
      op = 2'd0; base_addr = 15'd200; stride_x = 14'd1; stride_y = 14'd1;
      tiles_x = 4'd3; tiles_y = 4'd1; reg_base = 5'd0; start = 1'b1;
      e = '{is_done: 1'b0, func: FUNC_LOAD, addr: 15'd200, rg: 5'd0, at: s + 5, sx: 14'd1, sy: 14'd1};
      sbq.push_back(e);
      e = '{is_done: 1'b1, func: FUNC_NOP, addr: '0, rg: '0, at: s + 9, sx: '0, sy: '0};
      sbq.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      drain();
    end
`endif

    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom_range(0, 3)), 15'($urandom), 14'($urandom), 14'($urandom),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 5'($urandom),
            ($urandom_range(0, 3) == 0), s);
      drain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risk_tile_seq.md
Name: risk_tile_seq

Overview:
- Command sequencer that sits directly upstream of the risk tile unit and drives its risk_func, risk_reg, risk_addr, risk_stride_x and risk_stride_y inputs.
- Takes one 2D block descriptor and walks it tile by tile.
- Each tile is a 4x4 strided load, store or zero. The sequencer honours the memory pipeline latency so each load is captured on the correct cycle.

Parameters:
- LOAD_LAT, 4: cycles from address presentation to dat_r valid at the register file.
- STORE_LAT, 2: cycles the store address is held before the write-enable cycle.
- NREGS, 3: number of tile registers; the register index wraps at this value.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that launches a descriptor; ignored while busy
- op  input  2  0=load, 1=store, 2=zero, 3=reserved (treated as zero-tile-count)
- base_addr  input  15  element address of tile (0,0)
- stride_x  input  14  element stride along x within a tile
- stride_y  input  14  element stride along y within a tile
- tiles_x  input  4  tiles along x; 0 means empty
- tiles_y  input  4  tiles along y; 0 means empty
- reg_base  input  5  first destination/source register
- risk_func  output  3  to the risk unit; 3'b111 = NOP
- risk_reg  output  5  register index
- risk_addr  output  15  tile origin address
- risk_stride_x  output  14  registered copy of stride_x
- risk_stride_y  output  14  registered copy of stride_y
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the descriptor completes

Behaviour:
- Reset values: risk_func=NOP, risk_reg=0, risk_addr=0, strides=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-descriptor abandons the walk; the next cycle already shows NOP. No partial command is completed.
- States: IDLE, SETUP, ADDR, FIRE, NEXT, DONE.
- IDLE:
  - On start, latch all descriptor inputs → SETUP.
  - If tiles_x==0, tiles_y==0 or op==3 → DONE directly; no command is issued.
- SETUP (1 cycle):
  - Row pointer = col pointer = base_addr.
  - tx=ty=0; reg index = reg_base mod NREGS.
- ADDR:
  - Drive risk_addr = col pointer, func=NOP.
  - Hold for LAT-1 cycles, where LAT = LOAD_LAT for load and STORE_LAT for store; zero uses 0 hold cycles.
- FIRE (exactly 1 cycle): address held; func = 000 load / 001 store / 010 zero; risk_reg = current index.
- NEXT (1 cycle, func=NOP):
  - If tx+1<tiles_x: col += 4*stride_x, tx++.
  - Otherwise: row += 4*stride_y, col = row, tx=0, ty++.
  - Reg index += 1, wrapping to 0 at NREGS.
  - If the last tile is finished → DONE, else → ADDR.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Address arithmetic:
  - Done by incremental accumulation only; no multipliers.
  - Computed modulo 2^15; wrap-around is silent and legal.
  - 4*stride is the stride left-shifted by 2 and zero-extended to 15 bits.
- Throughput:
  - Load tile = LOAD_LAT+1 cycles (ADDR+FIRE+NEXT).
  - Zero tile = 2 cycles.
- start arriving in DONE or in any busy state is dropped. start arriving in the same cycle as reset is dropped.
- risk_stride_x/y are updated only in SETUP and are stable for the whole walk.

Optional Feature:
- Macro RISK_SEQ_ABORT_EN.
- With the macro: an extra input port abort (1 bit).
  - abort seen in ADDR or NEXT → DONE on the next cycle, with no further FIRE.
  - abort seen in FIRE lets that command complete, then → DONE.
  - done pulses normally.
- Without the macro: no port, and the walk always runs to completion.

Decomposition:
- Shared package risk_pkg holds:
  - func codes (LOAD=3'b000, STORE=3'b001, ZERO=3'b010, NOP=3'b111);
  - op encodings;
  - address width 15, stride width 14, tile edge 4;
  - default LOAD_LAT/STORE_LAT.
- One sub-module: risk_addr_walk.
  - Holds the row/col accumulators and tx/ty counters.
  - Has step/restart controls and a last flag.
  - The FSM stays in risk_tile_seq.

Test Plan:
- Load 2x2: base=100, stride_x=1, stride_y=64, reg_base=0 → FIRE addrs 100,104,356,360 with regs 0,1,2,0. Each FIRE preceded by 3 NOP cycles holding the address. done at cycle 1+1+4*5+1.
- Store 1x1: base=7, reg_base=2 → exactly one risk_func=001 cycle at addr 7, reg 2, preceded by 1 hold cycle.
- Zero-size: tiles_x=0, tiles_y=3 → no non-NOP func; done pulses 2 cycles after start.
- Wrap: base=32760, stride_x=2, tiles_x=2, op=zero → FIRE addrs 32760 then 0.
- Reset mid-walk: reset during the second ADDR of a 4-tile load → NOP next cycle, busy=0. A new start then runs cleanly from its own base.
- Start while busy: second start pulse mid-walk is ignored; only the first descriptor's tiles appear. With RISK_SEQ_ABORT_EN, abort in ADDR → no further FIRE, and done pulses.
